// File: rtl/stage_decision_unit.sv
// stage_decision_unit
// Cascade stage evaluator: accumulates weak-classifier votes per stage,
// compares each stage sum against the looked-up stage threshold and
// reports one face/no-face verdict per detection window.
// Build option: define STAGE_EARLY_REJECT_EN to end a window at its first
// failing stage; otherwise every stage is evaluated and the first failing
// stage is latched.
module stage_decision_unit #(
  parameter int NUM_STAGES = 22,
  parameter int VOTE_W     = 16,
  parameter int ACC_W      = 24,
  parameter int IDX_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              win_start,
  input  logic              vote_valid,
  output logic              vote_ready,
  input  logic [VOTE_W-1:0] vote_data,
  input  logic              vote_last,
  output logic [IDX_W-1:0]  stage_idx,
  input  logic [VOTE_W-1:0] stage_thresh,
  output logic              result_valid,
  output logic              result_face,
  output logic [IDX_W-1:0]  result_stage,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]        LAST_STAGE = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]        ALL_PASSED = IDX_W'(NUM_STAGES);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         stage_q, stage_d;
  logic                     face_q, face_d;
  logic [IDX_W-1:0]         rstage_q, rstage_d;

  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  acc_sat;
  logic signed [ACC_W-1:0]  thresh_ext;
  logic                     stage_pass;
  logic                     last_stage;

`ifndef STAGE_EARLY_REJECT_EN
  logic                     fail_q, fail_d;
  logic [IDX_W-1:0]         fstage_q, fstage_d;
  logic                     fail_now;
  logic [IDX_W-1:0]         first_fail;
`endif

  // Saturating accumulate: one guard bit detects overflow, result clamps
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-VOTE_W){vote_data[VOTE_W-1]}}, vote_data};
    acc_sat  = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Stage comparison against the sign-extended threshold; equality passes
  always_comb begin
    thresh_ext = {{(ACC_W-VOTE_W){stage_thresh[VOTE_W-1]}}, stage_thresh};
    stage_pass = (acc_q >= thresh_ext);
    last_stage = (stage_q == LAST_STAGE);
  end

`ifndef STAGE_EARLY_REJECT_EN
  // Merge the current stage outcome with any earlier failure
  always_comb begin
    fail_now   = fail_q | ~stage_pass;
    first_fail = fail_q ? fstage_q : stage_q;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    stage_d  = stage_q;
    face_d   = face_q;
    rstage_d = rstage_q;
`ifndef STAGE_EARLY_REJECT_EN
    fail_d   = fail_q;
    fstage_d = fstage_q;
`endif
    if (win_start) begin
      // win_start wins over any vote transfer or compare in the same cycle
      state_d = ACCUM;
      acc_d   = '0;
      stage_d = '0;
`ifndef STAGE_EARLY_REJECT_EN
      fail_d   = 1'b0;
      fstage_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCUM: begin
          if (vote_valid) begin
            acc_d = acc_sat;
            if (vote_last) begin
              state_d = COMPARE;
            end
          end
        end
        COMPARE: begin
`ifdef STAGE_EARLY_REJECT_EN
          if (!stage_pass) begin
            state_d  = DONE;
            face_d   = 1'b0;
            rstage_d = stage_q;
          end else if (last_stage) begin
            state_d  = DONE;
            face_d   = 1'b1;
            rstage_d = ALL_PASSED;
          end else begin
            state_d = ACCUM;
            stage_d = stage_q + IDX_W'(1);
            acc_d   = '0;
          end
`else
          // A failing stage is only recorded; the cascade carries on
          if (!stage_pass && !fail_q) begin
            fail_d   = 1'b1;
            fstage_d = stage_q;
          end
          if (last_stage) begin
            state_d  = DONE;
            face_d   = ~fail_now;
            rstage_d = fail_now ? first_fail : ALL_PASSED;
          end else begin
            state_d = ACCUM;
            stage_d = stage_q + IDX_W'(1);
            acc_d   = '0;
          end
`endif
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      stage_q  <= '0;
      face_q   <= 1'b0;
      rstage_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      stage_q  <= stage_d;
      face_q   <= face_d;
      rstage_q <= rstage_d;
    end
  end

`ifndef STAGE_EARLY_REJECT_EN
  // First-failure tracking registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_q   <= 1'b0;
      fstage_q <= '0;
    end else begin
      fail_q   <= fail_d;
      fstage_q <= fstage_d;
    end
  end
`endif

  // Outputs decoded from registered state
  always_comb begin
    vote_ready   = (state_q == ACCUM);
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
    stage_idx    = stage_q;
    result_face  = face_q;
    result_stage = rstage_q;
  end

endmodule

// File: tb/tb_stage_decision_unit.sv
// Testbench for stage_decision_unit: directed windows, verdicts checked
// by a scoreboard monitor, timing points checked inline.
module tb_stage_decision_unit;

  localparam int NS = 22;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        win_start = 1'b0;
  logic        vote_valid = 1'b0;
  logic        vote_ready;
  logic [15:0] vote_data = '0;
  logic        vote_last = 1'b0;
  logic [4:0]  stage_idx;
  logic [15:0] stage_thresh;
  logic        result_valid;
  logic        result_face;
  logic [4:0]  result_stage;
  logic        busy;

  logic [15:0] thr [0:NS-1];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       face;
    logic [4:0] stage;
  } res_t;

  res_t exp_q[$];

  stage_decision_unit #(
    .NUM_STAGES(22),
    .VOTE_W(16),
    .ACC_W(24)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .win_start(win_start),
    .vote_valid(vote_valid),
    .vote_ready(vote_ready),
    .vote_data(vote_data),
    .vote_last(vote_last),
    .stage_idx(stage_idx),
    .stage_thresh(stage_thresh),
    .result_valid(result_valid),
    .result_face(result_face),
    .result_stage(result_stage),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational threshold lookup
  always_comb begin
    stage_thresh = 16'h0000;
    if (stage_idx < 5'(NS)) stage_thresh = thr[stage_idx];
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every verdict strobe must match a queued expectation
  always @(negedge clk) begin
    if (reset_n && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: face=%0d stage=%0d with nothing expected",
                 result_face, result_stage);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result_face", int'(result_face), int'(e.face));
        check("result_stage", int'(result_stage), int'(e.stage));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input logic [15:0] d, input logic last);
    vote_valid = 1'b1;
    vote_data  = d;
    vote_last  = last;
    tick();
    vote_valid = 1'b0;
    vote_last  = 1'b0;
  endtask

  task automatic start();
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
  endtask

  task automatic set_thr_all(input logic [15:0] v);
    for (int i = 0; i < NS; i++) thr[i] = v;
  endtask

  // Remaining stages, one passing vote each, followed by the compare bubble
  task automatic pass_stages(input int from);
    for (int s = from; s < NS; s++) begin
      vote(16'h0100, 1'b1);
      tick();
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (!busy) done = 1'b1;
      else tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0d, expected 0 within 8 cycles", busy);
    end
  endtask

  initial begin
    int cnt;
    bit seen;
    set_thr_all(16'h0100);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_vote_ready", int'(vote_ready), 0);
    check("rst_stage_idx", int'(stage_idx), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_result_face", int'(result_face), 0);
    check("rst_result_stage", int'(result_stage), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    tick();

    // Window 1: stage pass, then abort during stage 5 (no verdict expected)
    thr[0] = 16'h00D3;
    start();
    check("start_busy", int'(busy), 1);
    check("start_vote_ready", int'(vote_ready), 1);
    check("start_stage_idx", int'(stage_idx), 0);
    vote(16'h0080, 1'b0);
    vote(16'h0060, 1'b1);
    check("compare_bubble_ready", int'(vote_ready), 0);
    check("compare_stage_idx", int'(stage_idx), 0);
    tick();
    check("pass_stage_idx", int'(stage_idx), 1);
    check("pass_vote_ready", int'(vote_ready), 1);
    check("pass_no_result", int'(result_valid), 0);
    for (int s = 1; s < 5; s++) begin
      vote(16'h0100, 1'b1);
      tick();
    end
    check("abort_pre_stage_idx", int'(stage_idx), 5);
    vote(16'hF000, 1'b0);
    vote_valid = 1'b1;
    vote_data  = 16'h0100;
    vote_last  = 1'b1;
    win_start  = 1'b1;
    tick();
    vote_valid = 1'b0;
    vote_last  = 1'b0;
    win_start  = 1'b0;
    check("abort_stage_idx", int'(stage_idx), 0);
    check("abort_busy", int'(busy), 1);
    check("abort_vote_ready", int'(vote_ready), 1);

    // Window 2 (restarted): acc cleared after abort and between stages; stage 3 fails
    set_thr_all(16'h0100);
    thr[0] = 16'h0000;
    thr[1] = 16'hFF00;
    thr[2] = 16'h0000;
    thr[3] = 16'h00D3;
    exp_q.push_back('{face: 1'b0, stage: 5'd3});
    vote(16'h0000, 1'b1); tick();
    vote(16'hFF80, 1'b1); tick();
    vote(16'h0000, 1'b1); tick();
    check("w2_stage_idx", int'(stage_idx), 3);
    vote(16'h0080, 1'b0);
    vote(16'h0050, 1'b1);
    tick();
`ifdef STAGE_EARLY_REJECT_EN
    check("w2_early_valid", int'(result_valid), 1);
    tick();
    check("w2_early_busy", int'(busy), 0);
`else
    check("w2_continue_stage_idx", int'(stage_idx), 4);
    pass_stages(4);
    wait_idle();
`endif

    // Window 3: equality passes everywhere, verdict latency 44 cycles
    set_thr_all(16'h0100);
    exp_q.push_back('{face: 1'b1, stage: 5'd22});
    start();
    cnt = 0;
    for (int s = 0; s < NS; s++) begin
      vote(16'h0100, 1'b1);
      cnt++;
      if (s < NS - 1) begin
        tick();
        cnt++;
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      cnt++;
      if (result_valid) seen = 1'b1;
    end
    check("full_pass_latency", cnt, 44);
    wait_idle();

    // Window 4: negative saturation, no wrap, stage 0 fails
    set_thr_all(16'h0100);
    thr[0] = 16'h8000;
    exp_q.push_back('{face: 1'b0, stage: 5'd0});
    start();
    repeat (300) vote(16'h8000, 1'b0);
    vote(16'h0001, 1'b1);
    tick();
`ifdef STAGE_EARLY_REJECT_EN
    check("negsat_valid", int'(result_valid), 1);
`else
    pass_stages(1);
`endif
    wait_idle();

    // Window 5: positive saturation, no wrap, all stages pass
    set_thr_all(16'h0100);
    thr[0] = 16'h7FFF;
    exp_q.push_back('{face: 1'b1, stage: 5'd22});
    start();
    repeat (300) vote(16'h7FFF, 1'b0);
    vote(16'h0000, 1'b1);
    tick();
    pass_stages(1);
    wait_idle();

    // Asynchronous reset mid-window discards it and clears held results
    set_thr_all(16'h0100);
    start();
    vote(16'h0100, 1'b0);
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(vote_ready), 0);
    check("async_rst_face", int'(result_face), 0);
    check("async_rst_stage", int'(result_stage), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", int'(result_valid), 0);

    // Window 6: stage 0 sum 0x00D0 below threshold 0x00D3
    thr[0] = 16'h00D3;
    exp_q.push_back('{face: 1'b0, stage: 5'd0});
    start();
    vote(16'h0080, 1'b0);
    vote(16'h0050, 1'b1);
    check("w6_compare_ready", int'(vote_ready), 0);
    tick();
`ifdef STAGE_EARLY_REJECT_EN
    check("w6_early_valid", int'(result_valid), 1);
    check("w6_done_ready", int'(vote_ready), 0);
    tick();
    check("w6_early_busy", int'(busy), 0);
`else
    check("w6_continue_stage_idx", int'(stage_idx), 1);
    pass_stages(1);
    wait_idle();
`endif

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
